// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) binary-to-BCD converter, one bit per clock.
// Optional two's-complement input handling is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  out_neg
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned RW = BW + IN_W;
  localparam int unsigned CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [IN_W-1:0] mag;
  logic [BW-1:0]   adj;
  logic            accept;

  assign accept = (state_q == StIdle) && in_valid;

`ifdef BIN2BCD_SIGNED_EN
  logic neg_q;

  // Negating the most negative value wraps to 2^(IN_W-1), which is the correct magnitude.
  assign mag = in_data[IN_W-1] ? -in_data : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= in_data[IN_W-1];
    end
  end

  assign out_neg = neg_q;
`else
  assign mag     = in_data;
  assign out_neg = 1'b0;
`endif

  // Add-3 correction on every BCD digit before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[4*i +: 4] = (sreg_q[IN_W + 4*i +: 4] >= 4'd5) ? sreg_q[IN_W + 4*i +: 4] + 4'd3
                                                         : sreg_q[IN_W + 4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sreg_d  = {{BW{1'b0}}, mag};
          cnt_d   = CW'(IN_W);
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d = {adj, sreg_q[IN_W-1:0]} << 1;
        // The bit shifted out of the top digit is lost from out_bcd, so flag it.
        ovf_d  = ovf_q | adj[BW-1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_bcd   = sreg_q[RW-1 -: BW];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit converter driven in lockstep,
// checked against directed vectors and a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        in_ready3, out_valid3, out_ovf3, out_neg3;
  logic [11:0] out_bcd3;
  logic        in_ready2, out_valid2, out_ovf2, out_neg2;
  logic [7:0]  out_bcd2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.IN_W(8), .DIGITS(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_bcd(out_bcd3), .out_ovf(out_ovf3),
    .out_neg(out_neg3)
  );

  bin2bcd_seq #(.IN_W(8), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_bcd(out_bcd2), .out_ovf(out_ovf2),
    .out_neg(out_neg2)
  );

  typedef struct {
    logic [7:0]  d;
    logic [11:0] b3;
    logic        o3;
    logic [7:0]  b2;
    logic        o2;
    logic        ng;
    int          hold;
  } vec_t;

  vec_t tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits of the magnitude by plain division.
  function automatic void model(input logic [7:0] d, output logic [11:0] b3, output logic o3,
                                output logic [7:0] b2, output logic o2, output logic ng);
    int v;
    v  = int'(d);
    ng = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (d[7]) begin
      v  = 256 - int'(d);
      ng = 1'b1;
    end
`endif
    o3 = (v >= 1000);
    o2 = (v >= 100);
    b3 = '0;
    b2 = '0;
    for (int i = 0; i < 3; i++) b3[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    for (int i = 0; i < 2; i++) b2[4*i +: 4] = 4'((v / (10 ** i)) % 10);
  endfunction

  // Called and returns at posedge+1; acc is the cycle index of the accept edge.
  task automatic do_conv(input logic [7:0] d, input logic [11:0] e3, input logic e3o,
                         input logic [7:0] e2, input logic e2o, input logic en,
                         input int hold, output int acc);
    int n;
    check("in_ready_idle", {30'd0, in_ready3, in_ready2}, 32'd3);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    acc      = cyc;
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom);
    check("in_ready_busy", {31'd0, in_ready3}, 32'd0);
    n = 0;
    while (!out_valid3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 8);
    check("valid_d2", {31'd0, out_valid2}, 32'd1);
    check("bcd_d3", {20'd0, out_bcd3}, {20'd0, e3});
    check("ovf_d3", {31'd0, out_ovf3}, {31'd0, e3o});
    check("bcd_d2", {24'd0, out_bcd2}, {24'd0, e2});
    check("ovf_d2", {31'd0, out_ovf2}, {31'd0, e2o});
    check("neg_d3", {31'd0, out_neg3}, {31'd0, en});
    check("neg_d2", {31'd0, out_neg2}, {31'd0, en});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid3}, 32'd1);
      check("hold_bcd", {20'd0, out_bcd3}, {20'd0, e3});
      check("hold_ovf", {31'd0, out_ovf3}, {31'd0, e3o});
      check("hold_in_ready", {31'd0, in_ready3}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("consumed_valid", {31'd0, out_valid3}, 32'd0);
    check("consumed_in_ready", {31'd0, in_ready3}, 32'd1);
  endtask

  task automatic run_model(input logic [7:0] d, input int hold, output int acc);
    logic [11:0] b3;
    logic [7:0]  b2;
    logic        o3, o2, ng;
    model(d, b3, o3, b2, o2, ng);
    do_conv(d, b3, o3, b2, o2, ng, hold, acc);
  endtask

  initial begin
    int a0, a1;
`ifdef BIN2BCD_SIGNED_EN
    tab[0] = '{8'd255, 12'h001, 1'b0, 8'h01, 1'b0, 1'b1, 0};
    tab[1] = '{8'h80,  12'h128, 1'b0, 8'h28, 1'b1, 1'b1, 0};
    tab[2] = '{8'h7F,  12'h127, 1'b0, 8'h27, 1'b1, 1'b0, 2};
    tab[3] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    tab[4] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0, 1};
    tab[5] = '{8'd137, 12'h119, 1'b0, 8'h19, 1'b1, 1'b1, 0};
    tab[6] = '{8'd200, 12'h056, 1'b0, 8'h56, 1'b0, 1'b1, 0};
    tab[7] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0, 1'b0, 3};
`else
    tab[0] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1, 1'b0, 0};
    tab[1] = '{8'h80,  12'h128, 1'b0, 8'h28, 1'b1, 1'b0, 0};
    tab[2] = '{8'h7F,  12'h127, 1'b0, 8'h27, 1'b1, 1'b0, 2};
    tab[3] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    tab[4] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0, 1};
    tab[5] = '{8'd137, 12'h137, 1'b0, 8'h37, 1'b1, 1'b0, 0};
    tab[6] = '{8'd200, 12'h200, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    tab[7] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0, 1'b0, 3};
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid3}, 32'd0);
    check("rst_bcd", {20'd0, out_bcd3}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf3}, 32'd0);
    check("rst_neg", {31'd0, out_neg3}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready3}, 32'd1);

    foreach (tab[i]) begin
      do_conv(tab[i].d, tab[i].b3, tab[i].o3, tab[i].b2, tab[i].o2, tab[i].ng, tab[i].hold, a0);
    end

    // Back-to-back accepts with out_ready held high: IN_W+2 cycles apart.
    run_model(8'd0, 0, a0);
    run_model(8'd99, 0, a1);
    check("accept_gap", a1 - a0, 10);

    // Result held across 5 cycles of backpressure.
    run_model(8'd137, 5, a0);

    // Reset after the 3rd SHIFT cycle discards the conversion.
    in_data  = 8'd255;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_bcd_pre", {31'd0, out_bcd3 != 12'h000}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid3}, 32'd0);
    check("midrst_bcd", {20'd0, out_bcd3}, 32'd0);
    check("midrst_ovf", {31'd0, out_ovf3}, 32'd0);
    check("midrst_neg", {31'd0, out_neg3}, 32'd0);
    check("midrst_bcd_d2", {24'd0, out_bcd2}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready3}, 32'd1);
    run_model(8'd42, 0, a0);

    for (int i = 0; i < 40; i++) begin
      run_model(8'($urandom), int'($urandom_range(0, 2)), a0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock. It turns an IN_W-bit binary value into DIGITS packed BCD digits, with a valid/ready handshake on both sides and a sticky overflow flag when the result does not fit. It sits between the binary datapath and the display and reporting formatters, and replaces the fixed 8-bit combinational converter where width, digit count or timing closure require it.

## Interface
- IN_W, 8, binary input width; must be ≥ 2.
- DIGITS, 3, number of BCD output digits; must be ≥ 1. Values with 10^DIGITS ≤ 2^IN_W−1 are legal and rely on out_ovf.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  converter can accept; high only in IDLE.
- in_data  input  IN_W  binary operand.
- out_valid  output  1  out_bcd, out_ovf and out_neg are valid.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- out_ovf  output  1  the result exceeded DIGITS digits; out_bcd holds the low DIGITS digits.
- out_neg  output  1  sign of the input; tied 0 unless BIN2BCD_SIGNED_EN is defined.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid && in_ready: load the shift register with the operand (magnitude in signed mode), clear the BCD accumulator and the ovf flag, load the bit counter with IN_W, then go to SHIFT.
- SHIFT, each cycle:
  - Every digit ≥ 5 gets +3.
  - The combined {BCD, binary} register then shifts left by 1.
  - If the bit leaving digit DIGITS−1 is 1, ovf is set (sticky).
  - The counter decrements. On the cycle the counter reaches 1, go to DONE.
- DONE
  - out_valid=1.
  - out_bcd, out_ovf and out_neg stay stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
- in_ready is 0 in SHIFT and DONE. Input is never accepted while a result is pending.
- Arithmetic: the add-3 is 4-bit and never overflows, because inputs are ≤ 9 before correction. The internal register is 4*DIGITS+IN_W bits wide.
- Reset clears the state to IDLE, out_bcd=0, out_ovf=0, out_neg=0, out_valid=0 and the counter to 0. in_ready=1 once reset is low.
- Reset asserted mid-SHIFT or in DONE discards the operation. There is no partial output.

## Timing
- Accept edge = edge T where in_valid && in_ready.
- out_valid rises after edge T+IN_W, i.e. exactly IN_W cycles of SHIFT.
- Minimum period between accepts is IN_W+2 cycles, with out_ready held high.
- out_ready sampled low in DONE: hold indefinitely, with no change to any output.
- in_valid may drop or change while in_ready=0 with no effect.
- Critical path is one 4-bit compare/add-3 per digit plus a 1-bit shift, independent of IN_W and DIGITS.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - in_data is two's complement.
  - At load, out_neg captures in_data[IN_W-1], and the magnitude (negated if negative) is loaded.
  - −2^(IN_W−1) is converted correctly as magnitude 2^(IN_W−1).
- Not defined: in_data is unsigned and out_neg is constant 0. There is no extra logic or latency in either case.

## Test plan
- IN_W=8, DIGITS=3, in_data=255 -> out_bcd=0x255, out_ovf=0, out_valid exactly 8 cycles after the accept edge.
- in_data=0 -> out_bcd=0x000, out_ovf=0. Then in_data=99 with out_ready held high -> 0x099, next accept exactly 10 cycles after the previous one.
- DIGITS=2, in_data=200 -> out_bcd=0x00, out_ovf=1. in_data=99 -> 0x99, out_ovf=0.
- out_ready held low for 5 cycles in DONE with in_data=137 -> out_bcd=0x137 held and in_ready=0 throughout. Result consumed on the first out_ready high edge, and in_ready=1 the next cycle.
- rst pulsed after the 3rd SHIFT cycle -> all outputs 0 immediately, state IDLE. A new conversion of 42 yields 0x042.
- BIN2BCD_SIGNED_EN, IN_W=8:
  - 0x80 -> out_neg=1, out_bcd=0x128.
  - 0xFF -> out_neg=1, out_bcd=0x001.
  - 0x7F -> out_neg=0, out_bcd=0x127.
